// File: rtl/ser_arb_pkg.sv
// Shared types and width helpers for the serializer arbiter.
package ser_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Width of a requester ID; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Width of the beat counter: holds FROM/TO-1 with one bit of headroom.
  function automatic int unsigned cnt_w(input int unsigned from, input int unsigned to);
    return unsigned'($clog2(from / to)) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned k;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!found && req[IW'(k)]) begin
        found          = 1'b1;
        gnt[IW'(k)]    = 1'b1;
        idx            = IW'(k);
      end
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Serializer arbiter: round-robin share of one shift serializer among NREQ requesters.
// Optional feature macro SER_ARB_LOCK_EN adds lock_i so the last owner can keep the serializer.
module serializer_arbiter
  import ser_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned FROM = 8,
  parameter int unsigned TO   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*FROM-1:0]     req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic [FROM-1:0]          ser_data_o,
  output logic                     ser_valid_o,
  input  logic                     ser_ready_i,
  input  logic                     ser_beat_i,
`ifdef SER_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock_i,
`endif
  output logic [id_w(NREQ)-1:0]    owner_o,
  output logic                     owner_valid_o,
  output logic                     last_beat_o
);

  localparam int unsigned IW    = id_w(NREQ);
  localparam int unsigned BEATS = FROM / TO;
  localparam int unsigned CW    = cnt_w(FROM, TO);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [FROM-1:0] hold_q, hold_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   owner_q, owner_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            lock_hit;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] grant;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Previous owner keeps the serializer while it holds lock and still requests.
`ifdef SER_ARB_LOCK_EN
  assign lock_hit = lock_i[owner_q] & req_valid_i[owner_q];
`else
  assign lock_hit = 1'b0;
`endif

  // Next-state, grant and strobe decode.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    grant       = '0;
    win_idx     = lock_hit ? owner_q : pick_idx;
    ser_valid_o = 1'b0;
    last_beat_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reset_n && ser_ready_i && pick_found) begin
          if (lock_hit) begin
            grant[owner_q] = 1'b1;
          end else begin
            grant    = pick_gnt;
            rr_ptr_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
          end
          hold_d  = req_data_i[32'(win_idx) * FROM +: FROM];
          owner_d = win_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ser_valid_o = 1'b1;
        cnt_d       = CW'(BEATS - 1);
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (ser_beat_i) begin
          if (cnt_q == '0) begin
            last_beat_o = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
    end
  end

  assign req_ready_o   = grant;
  assign ser_data_o    = hold_q;
  assign owner_o       = owner_q;
  assign owner_valid_o = (state_q != IDLE);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Self-checking bench for serializer_arbiter (NREQ=4, FROM=8, TO=2).
// Build with SER_ARB_LOCK_EN defined to also exercise lock_i.
module tb_serializer_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned FROM  = 8;
  localparam int unsigned TO    = 2;
  localparam int          BEATS = 4;

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ*FROM-1:0] req_data_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [FROM-1:0]      ser_data_o;
  logic                 ser_valid_o;
  logic                 ser_ready_i;
  logic                 ser_beat_i;
  logic [1:0]           owner_o;
  logic                 owner_valid_o;
  logic                 last_beat_o;
`ifdef SER_ARB_LOCK_EN
  logic [NREQ-1:0]      lock_i;
`endif

  int n_checks;
  int n_fail;

  serializer_arbiter #(
    .NREQ (NREQ),
    .FROM (FROM),
    .TO   (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .ser_data_o    (ser_data_o),
    .ser_valid_o   (ser_valid_o),
    .ser_ready_i   (ser_ready_i),
    .ser_beat_i    (ser_beat_i),
`ifdef SER_ARB_LOCK_EN
    .lock_i        (lock_i),
`endif
    .owner_o       (owner_o),
    .owner_valid_o (owner_valid_o),
    .last_beat_o   (last_beat_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_idle();
    req_valid_i = '0;
    req_data_i  = '0;
    ser_ready_i = 1'b1;
    ser_beat_i  = 1'b0;
`ifdef SER_ARB_LOCK_EN
    lock_i      = '0;
`endif
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference winner: first valid requester at or after start, wrapping.
  function automatic int rr_winner(input logic [NREQ-1:0] v, input int start);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (start + i) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    req_valid_i = 4'b1111;
    ser_beat_i  = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
    n_checks++;
    if (ser_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid got=%b exp=0", ser_valid_o); end
    n_checks++;
    if (ser_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_ser_data got=%h exp=00", ser_data_o); end
    n_checks++;
    if (owner_o !== 2'd0 || owner_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_owner got=%0d/%b exp=0/0", owner_o, owner_valid_o);
    end
    n_checks++;
    if (last_beat_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", last_beat_o); end
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    req_valid_i = 4'b0100;
    req_data_i[2*FROM +: FROM] = 8'hA5;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", req_ready_o); end
    @(negedge clk);
    req_valid_i = '0;
    #1;
    n_checks++;
    if (ser_valid_o !== 1'b1 || ser_data_o !== 8'hA5) begin
      n_fail++; $display("FAIL single_load got=%b/%h exp=1/a5", ser_valid_o, ser_data_o);
    end
    n_checks++;
    if (owner_o !== 2'd2 || owner_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL single_owner got=%0d/%b exp=2/1", owner_o, owner_valid_o);
    end
    for (int b = 1; b <= BEATS; b++) begin
      @(negedge clk);
      ser_beat_i = 1'b1;
      #1;
      n_checks++;
      if (last_beat_o !== (b == BEATS)) begin
        n_fail++; $display("FAIL single_last beat=%0d got=%b exp=%b", b, last_beat_o, (b == BEATS));
      end
    end
    @(negedge clk);
    ser_beat_i = 1'b0;
    #1;
    n_checks++;
    if (owner_valid_o !== 1'b0 || ser_data_o !== 8'hA5) begin
      n_fail++; $display("FAIL single_done got=%b/%h exp=0/a5", owner_valid_o, ser_data_o);
    end
  endtask

  task automatic test_round_robin();
    int gidx[$];
    int gcyc[$];
    logic prev_sv;
    int gi;
    prev_sv = 1'b0;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid_i = 4'b1111;
        for (int i = 0; i < NREQ; i++) req_data_i[i*FROM +: FROM] = 8'(8'h10 + i);
        ser_beat_i = 1'b1;
      end
      #1;
      n_checks++;
      if ($countones(req_ready_o) > 1) begin n_fail++; $display("FAIL rr_onehot cyc=%0d got=%b", c, req_ready_o); end
      if (req_ready_o != '0) begin
        gi = -1;
        for (int j = 0; j < NREQ; j++) if (req_ready_o[j]) gi = j;
        gidx.push_back(gi);
        gcyc.push_back(c);
      end
      n_checks++;
      if (prev_sv && ser_valid_o) begin n_fail++; $display("FAIL rr_sv_consec cyc=%0d got=1 exp=0", c); end
      prev_sv = ser_valid_o;
    end
    drive_idle();
    n_checks++;
    if (gidx.size() != 5) begin n_fail++; $display("FAIL rr_count got=%0d exp=5", gidx.size()); end
    for (int k = 0; k < gidx.size() && k < 5; k++) begin
      n_checks++;
      if (gidx[k] != k % NREQ || gcyc[k] != 6 * k) begin
        n_fail++; $display("FAIL rr_order k=%0d got=%0d@%0d exp=%0d@%0d", k, gidx[k], gcyc[k], k % NREQ, 6 * k);
      end
    end
  endtask

  task automatic test_ser_not_ready();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid_i = 4'b0010;
      ser_ready_i = 1'b0;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL notready_wait cyc=%0d got=%b exp=0000", c, req_ready_o); end
    end
    @(negedge clk);
    ser_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL notready_grant got=%b exp=0010", req_ready_o); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    @(negedge clk);
    req_valid_i = 4'b0100;
    req_data_i[2*FROM +: FROM] = 8'h5A;
    @(negedge clk);
    req_valid_i = '0;
    @(negedge clk);
    ser_beat_i = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (owner_valid_o !== 1'b0 || owner_o !== 2'd0 || ser_data_o !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outs got=%b/%0d/%h exp=0/0/00", owner_valid_o, owner_o, ser_data_o);
    end
    n_checks++;
    if (ser_valid_o !== 1'b0 || last_beat_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_strobes got=%b/%b/%b exp=0/0/0000", ser_valid_o, last_beat_o, req_ready_o);
    end
    @(negedge clk);
    ser_beat_i  = 1'b0;
    req_valid_i = 4'b1010;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL midreset_held got=%b exp=0000", req_ready_o); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL midreset_first got=%b exp=0010", req_ready_o); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid_i = '0;
      ser_beat_i  = 1'b1;
    end
  endtask

  task automatic test_spurious_beat();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid_i = '0;
      ser_beat_i  = 1'b1;
      #1;
      n_checks++;
      if (last_beat_o !== 1'b0 || owner_valid_o !== 1'b0 || ser_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL spurious_idle cyc=%0d got=%b/%b/%b exp=0/0/0", c, last_beat_o, owner_valid_o, ser_valid_o);
      end
    end
    @(negedge clk);
    ser_beat_i  = 1'b0;
    req_valid_i = 4'b0001;
    req_data_i[0 +: FROM] = 8'h3C;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL spurious_grant got=%b exp=0001", req_ready_o); end
    @(negedge clk);
    req_valid_i = '0;
    ser_beat_i  = 1'b1;
    #1;
    n_checks++;
    if (ser_valid_o !== 1'b1 || ser_data_o !== 8'h3C) begin
      n_fail++; $display("FAIL spurious_load got=%b/%h exp=1/3c", ser_valid_o, ser_data_o);
    end
    for (int b = 1; b <= BEATS; b++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (last_beat_o !== (b == BEATS)) begin
        n_fail++; $display("FAIL spurious_last beat=%0d got=%b exp=%b", b, last_beat_o, (b == BEATS));
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

`ifdef SER_ARB_LOCK_EN
  task automatic test_lock();
    int gidx[$];
    int exp_order[5];
    int gi;
    exp_order = '{0, 3, 3, 3, 0};
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req_valid_i = 4'b1001;
        ser_beat_i  = 1'b1;
      end
      lock_i = (c < 24) ? 4'b1000 : 4'b0000;
      #1;
      if (req_ready_o != '0) begin
        gi = -1;
        for (int j = 0; j < NREQ; j++) if (req_ready_o[j]) gi = j;
        gidx.push_back(gi);
      end
    end
    drive_idle();
    n_checks++;
    if (gidx.size() != 5) begin n_fail++; $display("FAIL lock_count got=%0d exp=5", gidx.size()); end
    for (int k = 0; k < gidx.size() && k < 5; k++) begin
      n_checks++;
      if (gidx[k] != exp_order[k]) begin n_fail++; $display("FAIL lock_order k=%0d got=%0d exp=%0d", k, gidx[k], exp_order[k]); end
    end
  endtask
`endif

  // Random traffic against a transaction-level model of the arbiter.
  task automatic test_random();
    int          m_ptr, m_owner, m_left, win;
    bit          m_busy, m_loadcyc, can, lockhit;
    logic [7:0]  m_word;
    logic [3:0]  exp_rdy;
    bit          exp_last;
    apply_reset();
    m_ptr = 0; m_owner = 0; m_left = 0; m_busy = 0; m_loadcyc = 0; m_word = 8'h00;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      req_valid_i = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) req_data_i[i*FROM +: FROM] = 8'($urandom);
      ser_ready_i = ($urandom_range(0, 9) < 8);
      ser_beat_i  = 1'($urandom_range(0, 1));
`ifdef SER_ARB_LOCK_EN
      lock_i = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      #1;
      lockhit = 1'b0;
`ifdef SER_ARB_LOCK_EN
      lockhit = lock_i[m_owner] && req_valid_i[m_owner];
`endif
      can = !m_busy && ser_ready_i && (req_valid_i != '0);
      win = -1;
      if (can) win = lockhit ? m_owner : rr_winner(req_valid_i, m_ptr);
      exp_rdy  = can ? (4'b0001 << win) : 4'b0000;
      exp_last = m_busy && !m_loadcyc && ser_beat_i && (m_left == 1);

      n_checks++;
      if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready_o, exp_rdy); end
      n_checks++;
      if (ser_valid_o !== m_loadcyc) begin n_fail++; $display("FAIL rand_ser_valid cyc=%0d got=%b exp=%b", c, ser_valid_o, m_loadcyc); end
      n_checks++;
      if (ser_data_o !== m_word) begin n_fail++; $display("FAIL rand_ser_data cyc=%0d got=%h exp=%h", c, ser_data_o, m_word); end
      n_checks++;
      if (owner_o !== 2'(m_owner)) begin n_fail++; $display("FAIL rand_owner cyc=%0d got=%0d exp=%0d", c, owner_o, m_owner); end
      n_checks++;
      if (owner_valid_o !== m_busy) begin n_fail++; $display("FAIL rand_owner_valid cyc=%0d got=%b exp=%b", c, owner_valid_o, m_busy); end
      n_checks++;
      if (last_beat_o !== exp_last) begin n_fail++; $display("FAIL rand_last cyc=%0d got=%b exp=%b", c, last_beat_o, exp_last); end

      if (can) begin
        m_busy    = 1'b1;
        m_loadcyc = 1'b1;
        m_left    = BEATS;
        m_word    = req_data_i[win*FROM +: FROM];
        m_owner   = win;
        if (!lockhit) m_ptr = (win + 1) % NREQ;
      end else if (m_loadcyc) begin
        m_loadcyc = 1'b0;
      end else if (m_busy && ser_beat_i) begin
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_ser_not_ready();
    test_reset_mid_drain();
    test_spurious_beat();
`ifdef SER_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
